// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O block: page and register-offset
// encodings plus a ceiling-log2 helper used to size counters.
package mmio_pkg;

  localparam logic [3:0] PAGE_IMEM = 4'h0;
  localparam logic [3:0] PAGE_LED  = 4'h1;
  localparam logic [3:0] PAGE_SEG7 = 4'h2;
  localparam logic [3:0] PAGE_SW   = 4'h3;
  localparam logic [3:0] PAGE_KEY  = 4'h4;

  localparam logic [1:0] OFS_DATA = 2'd0;
  localparam logic [1:0] OFS_SET  = 2'd1;
  localparam logic [1:0] OFS_EDGE = 2'd1;
  localparam logic [1:0] OFS_CLR  = 2'd2;
  localparam logic [1:0] OFS_MASK = 2'd2;

  // Ceiling log2, never less than 1 so a counter always has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit debouncer: the stable output only takes a new level after the
// synchronised input has differed from it for DEBOUNCE_CYCLES consecutive
// cycles. DEBOUNCE_CYCLES = 0 makes stable a plain register of the input.
module key_debounce
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_sync,
  output logic o_stable
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Bypass: stable tracks the synchronised level every cycle.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) o_stable <= 1'b0;
        else       o_stable <= i_sync;
      end
    end else begin : g_count
      localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] r_cnt;

      // Count cycles of disagreement; any agreement restarts the count.
      // The increment that would reach DEBOUNCE_CYCLES accepts the new level.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          r_cnt    <= '0;
          o_stable <= 1'b0;
        end else if (i_sync != o_stable) begin
          if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            o_stable <= i_sync;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: LED register, synchronised switches and
// debounced pushbuttons with rising-edge capture, plus a registered read mux
// whose one-cycle latency matches the instruction memory.
// Optional feature macro KEY_IRQ_EN: adds the key interrupt mask register and
// a registered irq; without it KEY:2 reads 0 and irq is tied low.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int N_SW            = 9,
  parameter int N_KEY           = 3,
  parameter int N_LED           = 9,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      ADDR,
  input  logic [15:0]      DOUT,
  input  logic             W,
  input  logic [N_SW-1:0]  SW_in,
  input  logic [N_KEY-1:0] KEY_in,
  output logic [N_LED-1:0] LED_out,
  output logic             hit,
  output logic [15:0]      rd_data,
  output logic             irq
);

  logic [3:0]       w_page;
  logic [1:0]       w_ofs;
  logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
  logic [N_KEY-1:0] r_key_s1, r_key_s2;
  logic [N_KEY-1:0] w_stable, r_stable_q, w_rise, w_clr;
  logic [N_KEY-1:0] r_edge;
  logic [N_KEY-1:0] w_mask;
  logic [15:0]      w_rd;
  logic             w_unused;

  assign w_page = ADDR[15:12];
  assign w_ofs  = ADDR[1:0];
  // Address bits [11:2] alias and upper write-data bits have no home.
  assign w_unused = ^{ADDR[11:2], DOUT};

  assign hit = (w_page == PAGE_LED) || (w_page == PAGE_SW) || (w_page == PAGE_KEY);

  // Two-flop synchronisers; keys are inverted so pressed reads as 1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= '0;
      r_key_s2 <= '0;
    end else begin
      r_sw_s1  <= SW_in;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= ~KEY_in;
      r_key_s2 <= r_key_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_KEY; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_sync  (r_key_s2[gi]),
        .o_stable(w_stable[gi])
      );
    end
  endgenerate

  assign w_rise = w_stable & ~r_stable_q;
  assign w_clr  = (W && w_page == PAGE_KEY && w_ofs == OFS_EDGE) ? DOUT[N_KEY-1:0] : '0;

  // Edge capture: write-1-to-clear, but a same-cycle rise keeps the bit set.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_stable_q <= '0;
      r_edge     <= '0;
    end else begin
      r_stable_q <= w_stable;
      r_edge     <= (r_edge & ~w_clr) | w_rise;
    end
  end

  // LED register: load, bit-set and bit-clear at offsets 0/1/2.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      LED_out <= '0;
    end else if (W && w_page == PAGE_LED) begin
      case (w_ofs)
        OFS_DATA: LED_out <= DOUT[N_LED-1:0];
        OFS_SET:  LED_out <= LED_out | DOUT[N_LED-1:0];
        OFS_CLR:  LED_out <= LED_out & ~DOUT[N_LED-1:0];
        default:  LED_out <= LED_out;
      endcase
    end
  end

`ifdef KEY_IRQ_EN
  logic [N_KEY-1:0] r_mask;

  // Interrupt mask register and registered interrupt request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mask <= '0;
      irq    <= 1'b0;
    end else begin
      if (W && w_page == PAGE_KEY && w_ofs == OFS_MASK) r_mask <= DOUT[N_KEY-1:0];
      irq <= |(r_edge & r_mask);
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  // Read mux; unused upper bits stay zero.
  always_comb begin
    w_rd = '0;
    case (w_page)
      PAGE_LED: w_rd[N_LED-1:0] = LED_out;
      PAGE_SW:  w_rd[N_SW-1:0]  = r_sw_s2;
      PAGE_KEY: begin
        case (w_ofs)
          OFS_DATA: w_rd[N_KEY-1:0] = w_stable;
          OFS_EDGE: w_rd[N_KEY-1:0] = r_edge;
          OFS_MASK: w_rd[N_KEY-1:0] = w_mask;
          default:  w_rd = '0;
        endcase
      end
      default: w_rd = '0;
    endcase
  end

  // Registered read data; a same-cycle write is seen only on the next read.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rd_data <= '0;
    else       rd_data <= w_rd;
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: stimulus pushes expected values,
// a monitor pops and compares one cycle after each check request.
module tb_mmio_io_ctrl;

  localparam int N_SW = 9, N_KEY = 3, N_LED = 9, DBC = 16;
  localparam int K_RD = 0, K_LED = 1, K_IRQ = 2, K_HIT = 3;

  logic             Clock, Reset, W, hit, irq;
  logic [15:0]      ADDR, DOUT, rd_data;
  logic [N_SW-1:0]  SW_in;
  logic [N_KEY-1:0] KEY_in;
  logic [N_LED-1:0] LED_out;

  mmio_io_ctrl #(.N_SW(N_SW), .N_KEY(N_KEY), .N_LED(N_LED), .DEBOUNCE_CYCLES(DBC)) dut (
    .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .SW_in(SW_in), .KEY_in(KEY_in), .LED_out(LED_out), .hit(hit),
    .rd_data(rd_data), .irq(irq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          q_kind[$];
  logic [15:0] q_exp[$];
  string       q_name[$];
  logic        go;
  int          n_pass, n_tot;

  int          m_kind;
  logic [15:0] m_exp, m_act;
  string       m_name;

  // Monitor: a check requested this cycle is compared just after the edge.
  always @(posedge Clock) begin
    if (go) begin
      #1;
      n_tot++;
      if (q_exp.size() == 0) begin
        $display("FAIL scoreboard_underflow: no expected value queued");
      end else begin
        m_kind = q_kind.pop_front();
        m_exp  = q_exp.pop_front();
        m_name = q_name.pop_front();
        case (m_kind)
          K_RD:    m_act = rd_data;
          K_LED:   m_act = 16'(LED_out);
          K_IRQ:   m_act = {15'b0, irq};
          default: m_act = {15'b0, hit};
        endcase
        if (m_act === m_exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
      end
    end
  end

  // Called at a negedge; occupies one cycle.
  task automatic chk(input int kind, input logic [15:0] addr, input logic [15:0] exp, input string name);
    ADDR = addr;
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
    go = 1'b1;
    @(negedge Clock);
    go = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    ADDR = addr; DOUT = data; W = 1'b1;
    @(negedge Clock);
    W = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_tot = 0; go = 1'b0;
    Reset = 1'b1; W = 1'b0; ADDR = '0; DOUT = '0; SW_in = '0; KEY_in = '1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    // 1. reset state
    chk(K_LED, 16'h1000, 16'h0000, "rst_led");
    chk(K_RD,  16'h1000, 16'h0000, "rst_rd_led");
    chk(K_RD,  16'h3000, 16'h0000, "rst_rd_sw");
    chk(K_RD,  16'h4000, 16'h0000, "rst_rd_key");
    chk(K_RD,  16'h4001, 16'h0000, "rst_rd_edge");
    chk(K_IRQ, 16'h4001, 16'h0000, "rst_irq");

    // page decode
    chk(K_HIT, 16'h1000, 16'h0001, "hit_led");
    chk(K_HIT, 16'h3FFF, 16'h0001, "hit_sw");
    chk(K_HIT, 16'h4003, 16'h0001, "hit_key");
    chk(K_HIT, 16'h2000, 16'h0000, "hit_seg7");
    chk(K_HIT, 16'h5000, 16'h0000, "hit_other");

    // 2. LED load / set / clear
    wr(16'h1000, 16'h01A5);
    wr(16'h1001, 16'h0002);
    chk(K_LED, 16'h1000, 16'h01A7, "led_set");
    wr(16'h1002, 16'h0004);
    chk(K_LED, 16'h1000, 16'h01A3, "led_clr");
    chk(K_RD,  16'h1000, 16'h01A3, "rd_led");
    wr(16'h1003, 16'h0FFF);
    chk(K_LED, 16'h1000, 16'h01A3, "led_ofs3_ignored");
    // read combined with write returns the pre-write value
    DOUT = 16'h00FF; W = 1'b1;
    chk(K_RD, 16'h1000, 16'h01A3, "rd_during_wr");
    W = 1'b0;
    chk(K_LED, 16'h1000, 16'h00FF, "led_after_rdwr");
    chk(K_RD,  16'h2000, 16'h0000, "rd_unmapped");

    // 3. switches
    SW_in = 9'h155;
    repeat (2) @(negedge Clock);
    chk(K_RD, 16'h3000, 16'h0155, "rd_sw");
    chk(K_RD, 16'h3ABC, 16'h0155, "rd_sw_alias");

    // 4. bouncing key 1, then held pressed
    for (int i = 0; i < 10; i++) begin
      KEY_in[1] = ~KEY_in[1];
      repeat (3) @(negedge Clock);
    end
    KEY_in[1] = 1'b0;
    for (int k = 1; k <= 20; k++)
      chk(K_RD, 16'h4000, (k >= 19) ? 16'h0002 : 16'h0000, $sformatf("db_stable_c%0d", k));
    chk(K_RD, 16'h4001, 16'h0002, "edge_after_press");

    // 5. clear with no press, then clear colliding with a new press
    wr(16'h4001, 16'h0002);
    chk(K_RD, 16'h4001, 16'h0000, "edge_clr");
    KEY_in[1] = 1'b1;
    repeat (22) @(negedge Clock);
    chk(K_RD, 16'h4000, 16'h0000, "released");
    KEY_in[1] = 1'b0;
    repeat (18) @(negedge Clock);
    wr(16'h4001, 16'h0002);
    chk(K_RD, 16'h4001, 16'h0002, "set_beats_clr");
    wr(16'h4001, 16'h0002);
    chk(K_RD, 16'h4001, 16'h0000, "edge_clr2");

    // 6. mask and interrupt
    wr(16'h4002, 16'h0004);
`ifdef KEY_IRQ_EN
    chk(K_RD, 16'h4002, 16'h0004, "rd_mask");
`else
    chk(K_RD, 16'h4002, 16'h0000, "rd_mask_absent");
`endif
    chk(K_RD, 16'h4003, 16'h0000, "rd_key3");
    KEY_in[2] = 1'b0;
    repeat (18) @(negedge Clock);
    chk(K_IRQ, 16'h4001, 16'h0000, "irq_before");
`ifdef KEY_IRQ_EN
    chk(K_IRQ, 16'h4001, 16'h0001, "irq_assert");
`else
    chk(K_IRQ, 16'h4001, 16'h0000, "irq_tied");
`endif
    chk(K_RD, 16'h4001, 16'h0004, "edge2");
    wr(16'h4001, 16'h0004);
    chk(K_IRQ, 16'h4001, 16'h0000, "irq_cleared");

    // reset mid-debounce clears everything
    KEY_in[0] = 1'b0;
    repeat (8) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk(K_LED, 16'h1000, 16'h0000, "rst2_led");
    chk(K_RD,  16'h4000, 16'h0000, "rst2_stable");
    chk(K_RD,  16'h4001, 16'h0000, "rst2_edge");
    chk(K_RD,  16'h4002, 16'h0000, "rst2_mask");
    chk(K_IRQ, 16'h4002, 16'h0000, "rst2_irq");

    for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge Clock);
    if (q_exp.size() != 0) begin
      n_tot++;
      $display("FAIL drain: %0d checks left, expected 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
